// File: rtl/syn_clk_div_gen.sv
// rtl/syn_clk_div_gen.sv - WM8731 MCLK/BCLK/LRCLK generator with frame-aligned profile switching
`timescale 1ns/1ps
module syn_clk_div_gen #(
    parameter int P_LB_DATA_W    = 16,
    parameter int P_LB_ADDR_W    = 8,
    parameter int P_NUM_PROFILES = 4,
    parameter int P_DIV_W        = 8,
    parameter int P_LR_BITS      = 32
) (
    input  logic                   clk_ir,
    input  logic                   rst_sync_l,
    input  logic                   lb_wr_en,
    input  logic                   lb_rd_en,
    input  logic [P_LB_ADDR_W-1:0] lb_addr,
    input  logic [P_LB_DATA_W-1:0] lb_wr_data,
    output logic                   lb_wr_valid,
    output logic                   lb_rd_valid,
    output logic [P_LB_DATA_W-1:0] lb_rd_data,
    output logic                   mclk_o,
    output logic                   bclk_o,
    output logic                   lrclk_o,
    output logic                   running_o
);

    localparam int P_SEL_W = (P_NUM_PROFILES > 1) ? $clog2(P_NUM_PROFILES) : 1;
    localparam int LR_CW   = (P_LR_BITS > 1) ? $clog2(P_LR_BITS) : 1;

    localparam logic [P_LB_ADDR_W-1:0] A_CTRL     = P_LB_ADDR_W'(8'h00);
    localparam logic [P_LB_ADDR_W-1:0] A_DIV_BASE = P_LB_ADDR_W'(8'h10);
    localparam logic [P_LB_ADDR_W-1:0] A_BDIV     = P_LB_ADDR_W'(8'h20);
    localparam logic [P_LB_ADDR_W-1:0] A_STATUS   = P_LB_ADDR_W'(8'h21);
    localparam logic [P_DIV_W-1:0]     DIV_ONE    = P_DIV_W'(1);
    localparam logic [LR_CW-1:0]       LR_LAST    = LR_CW'(P_LR_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   pending_q, pending_d;
    logic                   ctrl_en_q, ctrl_en_d;
    logic [P_SEL_W-1:0]     ctrl_sel_q, ctrl_sel_d;
    logic [P_DIV_W-1:0]     div_q [P_NUM_PROFILES];
    logic [P_DIV_W-1:0]     div_d [P_NUM_PROFILES];
    logic [P_DIV_W-1:0]     bdiv_q, bdiv_d;

    logic [P_SEL_W-1:0]     act_sel_q, act_sel_d;
    logic [P_DIV_W-1:0]     act_div_q, act_div_d;
    logic [P_DIV_W-1:0]     act_bdiv_q, act_bdiv_d;

    logic [P_DIV_W-1:0]     mclk_cnt_q, mclk_cnt_d;
    logic [P_DIV_W-1:0]     bclk_cnt_q, bclk_cnt_d;
    logic [LR_CW-1:0]       lr_cnt_q, lr_cnt_d;
    logic                   mclk_q, mclk_d;
    logic                   bclk_q, bclk_d;
    logic                   lrclk_q, lrclk_d;

    logic                   wr_valid_q, rd_valid_q;
    logic [P_LB_DATA_W-1:0] rd_data_q, rd_data_d;

    logic                      wr_ctrl, wr_bdiv, wr_act_div, cfg_wr;
    logic [P_NUM_PROFILES-1:0] wr_div;
    logic [P_DIV_W-1:0]        sel_div_q, sel_div_d;
    logic                      mclk_tc, mclk_fall, bclk_tc, bclk_tog, bclk_fall, lr_tog;
    logic                      active, boundary;
    logic                      unused_wr_bits;

    function automatic logic [P_DIV_W-1:0] nz_div(input logic [P_DIV_W-1:0] v);
        return (v == '0) ? DIV_ONE : v;
    endfunction

    assign unused_wr_bits = ^lb_wr_data;

    // Bus decode; only writes that touch the live configuration count as cfg_wr.
    always_comb begin
        wr_ctrl    = lb_wr_en && (lb_addr == A_CTRL);
        wr_bdiv    = lb_wr_en && (lb_addr == A_BDIV);
        wr_act_div = 1'b0;
        for (int i = 0; i < P_NUM_PROFILES; i++) begin
            wr_div[i] = lb_wr_en && (lb_addr == A_DIV_BASE + P_LB_ADDR_W'(i));
            if (wr_div[i] && (act_sel_q == P_SEL_W'(i))) begin
                wr_act_div = 1'b1;
            end
        end
        cfg_wr = wr_ctrl || wr_bdiv || wr_act_div;
    end

    always_comb begin
        ctrl_en_d  = ctrl_en_q;
        ctrl_sel_d = ctrl_sel_q;
        bdiv_d     = bdiv_q;
        for (int i = 0; i < P_NUM_PROFILES; i++) begin
            div_d[i] = wr_div[i] ? lb_wr_data[P_DIV_W-1:0] : div_q[i];
        end
        if (wr_ctrl) begin
            ctrl_en_d  = lb_wr_data[15];
            ctrl_sel_d = lb_wr_data[P_SEL_W-1:0];
        end
        if (wr_bdiv) begin
            bdiv_d = lb_wr_data[P_DIV_W-1:0];
        end
    end

    // An out-of-range select falls back to divide-by-one.
    always_comb begin
        sel_div_q = DIV_ONE;
        sel_div_d = DIV_ONE;
        for (int i = 0; i < P_NUM_PROFILES; i++) begin
            if (ctrl_sel_q == P_SEL_W'(i)) sel_div_q = div_q[i];
            if (ctrl_sel_d == P_SEL_W'(i)) sel_div_d = div_d[i];
        end
    end

    always_comb begin
        active    = (state_q != S_IDLE);
        mclk_tc   = (mclk_cnt_q == act_div_q - DIV_ONE);
        mclk_fall = mclk_tc && mclk_q;
        bclk_tc   = (bclk_cnt_q == act_bdiv_q - DIV_ONE);
        bclk_tog  = mclk_fall && bclk_tc;
        bclk_fall = bclk_tog && bclk_q;
        lr_tog    = bclk_fall && (lr_cnt_q == LR_LAST);
        boundary  = active && lr_tog && lrclk_q;
    end

    // At the boundary every clock is high and about to fall, so clearing is glitch-free.
    always_comb begin
        mclk_cnt_d = '0;
        bclk_cnt_d = '0;
        lr_cnt_d   = '0;
        mclk_d     = 1'b0;
        bclk_d     = 1'b0;
        lrclk_d    = 1'b0;
        if (active && !boundary) begin
            mclk_cnt_d = mclk_tc ? '0 : mclk_cnt_q + DIV_ONE;
            mclk_d     = mclk_q ^ mclk_tc;
            bclk_cnt_d = bclk_cnt_q;
            if (mclk_fall) begin
                bclk_cnt_d = bclk_tc ? '0 : bclk_cnt_q + DIV_ONE;
            end
            bclk_d   = bclk_q ^ bclk_tog;
            lr_cnt_d = lr_cnt_q;
            if (bclk_fall) begin
                lr_cnt_d = (lr_cnt_q == LR_LAST) ? '0 : lr_cnt_q + LR_CW'(1);
            end
            lrclk_d = lrclk_q ^ lr_tog;
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        act_sel_d  = act_sel_q;
        act_div_d  = act_div_q;
        act_bdiv_d = act_bdiv_q;
        case (state_q)
            S_IDLE: begin
                pending_d = 1'b0;
                if (ctrl_en_q) begin
                    state_d    = S_RUN;
                    act_sel_d  = ctrl_sel_d;
                    act_div_d  = nz_div(sel_div_d);
                    act_bdiv_d = nz_div(bdiv_d);
                end
            end
            S_RUN, S_DRAIN: begin
                if (boundary) begin
                    // Reload from pre-write values; a coincident write waits for the next frame.
                    act_sel_d  = ctrl_sel_q;
                    act_div_d  = nz_div(sel_div_q);
                    act_bdiv_d = nz_div(bdiv_q);
                    if ((state_q == S_DRAIN) && !ctrl_en_q) begin
                        state_d   = S_IDLE;
                        pending_d = 1'b0;
                    end else begin
                        state_d   = cfg_wr ? S_DRAIN : S_RUN;
                        pending_d = cfg_wr;
                    end
                end else if (cfg_wr) begin
                    state_d   = S_DRAIN;
                    pending_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        rd_data_d = P_LB_DATA_W'(16'hdead);
        if (lb_addr == A_CTRL) begin
            rd_data_d              = '0;
            rd_data_d[15]          = ctrl_en_q;
            rd_data_d[P_SEL_W-1:0] = ctrl_sel_q;
        end else if (lb_addr == A_BDIV) begin
            rd_data_d              = '0;
            rd_data_d[P_DIV_W-1:0] = bdiv_q;
        end else if (lb_addr == A_STATUS) begin
            rd_data_d    = '0;
            rd_data_d[0] = pending_q;
            rd_data_d[1] = active;
        end else begin
            for (int i = 0; i < P_NUM_PROFILES; i++) begin
                if (lb_addr == A_DIV_BASE + P_LB_ADDR_W'(i)) begin
                    rd_data_d              = '0;
                    rd_data_d[P_DIV_W-1:0] = div_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            state_q    <= S_IDLE;
            pending_q  <= 1'b0;
            ctrl_en_q  <= 1'b0;
            ctrl_sel_q <= '0;
            for (int i = 0; i < P_NUM_PROFILES; i++) begin
                div_q[i] <= DIV_ONE;
            end
            bdiv_q     <= DIV_ONE;
            act_sel_q  <= '0;
            act_div_q  <= DIV_ONE;
            act_bdiv_q <= DIV_ONE;
            mclk_cnt_q <= '0;
            bclk_cnt_q <= '0;
            lr_cnt_q   <= '0;
            mclk_q     <= 1'b0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            ctrl_en_q  <= ctrl_en_d;
            ctrl_sel_q <= ctrl_sel_d;
            for (int i = 0; i < P_NUM_PROFILES; i++) begin
                div_q[i] <= div_d[i];
            end
            bdiv_q     <= bdiv_d;
            act_sel_q  <= act_sel_d;
            act_div_q  <= act_div_d;
            act_bdiv_q <= act_bdiv_d;
            mclk_cnt_q <= mclk_cnt_d;
            bclk_cnt_q <= bclk_cnt_d;
            lr_cnt_q   <= lr_cnt_d;
            mclk_q     <= mclk_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            wr_valid_q <= lb_wr_en;
            rd_valid_q <= lb_rd_en;
            rd_data_q  <= rd_data_d;
        end
    end

    assign lb_wr_valid = wr_valid_q;
    assign lb_rd_valid = rd_valid_q;
    assign lb_rd_data  = rd_data_q;
    assign mclk_o      = mclk_q;
    assign bclk_o      = bclk_q;
    assign lrclk_o     = lrclk_q;
    assign running_o   = (state_q != S_IDLE);

endmodule

// File: doc/syn_clk_div_gen.md
Name: syn_clk_div_gen

Overview:
- Programmable codec clock generator for the WM8731 path in the audio cortex.
- Derives MCLK, BCLK and LRCLK from one system clock using N register-programmable divide profiles, selected over the acortex local bus.
- Profile changes, divider changes and enable/disable are applied only at an LRCLK frame boundary, so the codec never sees a runt pulse or a truncated frame.

Parameters:
- P_LB_DATA_W, 16, local bus data width
- P_LB_ADDR_W, 8, local bus address width
- P_NUM_PROFILES, 4, number of selectable MCLK divide profiles
- P_DIV_W, 8, MCLK/BCLK divider field width
- P_LR_BITS, 32, BCLK periods per LRCLK half-period
- P_SEL_W, $clog2(P_NUM_PROFILES), local: profile select width

Ports:
- clk_ir  in  1  system clock
- rst_sync_l  in  1  reset; one clock; asynchronous, active-low
- lb_wr_en  in  1  write strobe
- lb_rd_en  in  1  read strobe
- lb_addr  in  P_LB_ADDR_W  register address
- lb_wr_data  in  P_LB_DATA_W  write data
- lb_wr_valid  out  1  write acknowledge
- lb_rd_valid  out  1  read data valid
- lb_rd_data  out  P_LB_DATA_W  read data
- mclk_o  out  1  codec master clock
- bclk_o  out  1  codec bit clock
- lrclk_o  out  1  codec left/right clock
- running_o  out  1  high while in RUN or DRAIN

Behaviour:
- Reset: all outputs 0; CTRL=0; DIV[i]=1; BCLK_DIV=1; state IDLE. Reset is valid mid-operation and forces all clocks low immediately.
- Register map:
  - 0x00 CTRL: [15] en, [P_SEL_W-1:0] sel.
  - 0x10+i DIV[i], i<P_NUM_PROFILES: [P_DIV_W-1:0].
  - 0x20 BCLK_DIV: [P_DIV_W-1:0].
  - 0x21 STATUS (read-only): [0] pending, [1] running.
- Bus timing:
  - lb_wr_valid = lb_wr_en delayed 1 cycle. lb_rd_valid = lb_rd_en delayed 1 cycle.
  - lb_rd_data is registered from lb_addr every cycle; unmapped address returns 'hdead; unused bits read 0.
- Working registers: act_div and act_bdiv are loaded from DIV[sel] and BCLK_DIV on IDLE->RUN and at every frame boundary. A divider value of 0 is treated as 1.
- Clock generation (RUN/DRAIN):
  - mclk_cnt counts 0..act_div-1; on the terminal count, mclk_o toggles. MCLK period = 2*act_div clk cycles.
  - bclk_o toggles after every act_bdiv MCLK falling edges.
  - lrclk_o toggles after every P_LR_BITS BCLK falling edges.
- Frame boundary: the cycle in which lrclk_o would toggle 1->0. In that cycle all three clocks go low together and all counters clear.
- FSM:
  - IDLE: outputs low. When CTRL.en=1, go to RUN on the next cycle with counters at 0. First mclk_o rise is act_div cycles after entering RUN.
  - RUN: a CTRL write, or a write to DIV[active sel] or BCLK_DIV, sets pending=1 and moves to DRAIN. Clocks continue unchanged.
  - DRAIN: at the frame boundary, clear pending and reload the working registers. If en=1 go to RUN, else go to IDLE.
- pending: writes made in IDLE apply immediately and never set pending. pending reads 1 from the cycle after the write until the cycle after the boundary.
- Simultaneous write and boundary: the boundary applies register values from before the write. The write sets pending again, and the FSM returns to DRAIN (or stays pending for the next boundary).
- Writes to inactive DIV profiles never set pending.

Test Plan:
- Reset with outputs mid-toggle -> mclk_o/bclk_o/lrclk_o/running_o all 0 in the same cycle; STATUS reads 0x0000; CTRL reads 0x0000.
- DIV[0]=2, BCLK_DIV=2, CTRL=0x8000 -> running_o=1; MCLK period 4 clk, BCLK period 16 clk, LRCLK period 1024 clk; first mclk_o rise 2 cycles after entering RUN.
- Running profile 0; write DIV[1]=3, then CTRL=0x8001 -> STATUS.pending=1; profile-0 frame completes intact; after the boundary MCLK period is 6 clk and pending=0.
- Write CTRL=0x0000 mid-frame -> clocks continue to the frame boundary, then all go low; running_o=0 and state IDLE.
- Write CTRL in the exact boundary cycle -> old configuration applied; pending remains 1; new configuration applied at the following boundary.
- Read 0x55 -> lb_rd_data=0xdead with lb_rd_valid 1 cycle after lb_rd_en; write to DIV[2] while profile 0 active -> pending stays 0.
